wb_stage_pipe: RTL
==================

// Module: wb_stage_pipe
// PURPOSE
//  Parametrised writeback stage: MEM/WB pipeline register, N-way writeback-data select,
//  register-file write enable, WB->EX forwarding tap, sticky halt and retire counter.
//  Sits between the memory stage and the register file in each core. Replaces the
//  fixed 4-source combinational writeback select.
// PARAMETERS
//  WORD_W   32  data word width
//  NSRC     5   number of writeback sources (dmemload, out_port, next_memaddr, u_type, sc_result)
//  SEL_W    3   select width; must satisfy 2**SEL_W >= NSRC
//  RADDR_W  5   register address width
//  CNT_W    32  retire counter width
// PORTS
//  CLK          in   1               clock, rising edge
//  nRST         in   1               reset, asynchronous, active-low
//  en           in   1               advance enable (ihit/dhit-derived); 0 = stall
//  flush        in   1               squash the instruction entering WB
//  mem_valid    in   1               MEM-stage slot holds a real instruction
//  final_mux    in   SEL_W           writeback source select
//  src_data     in   NSRC*WORD_W     packed sources; source k = bits [k*WORD_W +: WORD_W]
//  mem_rd       in   RADDR_W         destination register
//  mem_regwen   in   1               instruction writes a register
//  temp_halt    in   1               instruction is HALT
//  wdat         out  WORD_W          register-file write data
//  wsel         out  RADDR_W         register-file write address
//  WEN          out  1               register-file write enable
//  fwd_valid    out  1               forwarding tap valid
//  fwd_rd       out  RADDR_W         forwarding destination
//  fwd_data     out  WORD_W          forwarding data (= wdat)
//  halt         out  1               core halted (sticky)
//  retire_cnt   out  CNT_W           retired instruction count
// BEHAVIOUR
//  Reset (nRST=0, async): valid_q=0, all latched fields 0, state=RUN, retire_cnt=0;
//   hence wdat=0, wsel=0, WEN=0, fwd_valid=0, halt=0.
//  Pipeline register (posedge CLK, state RUN only):
//   flush=1            -> valid_q<=0, other fields unchanged (flush wins over en)
//   flush=0, en=1      -> capture mem_valid, final_mux, src_data, mem_rd, mem_regwen, temp_halt
//   flush=0, en=0      -> hold all fields
//   state HALTED       -> hold all fields, ignore en/flush
//  Select (combinational from latched fields): wdat = src[sel_q] if sel_q < NSRC, else 0.
//  wsel = rd_q.
//  live = valid_q & regwen_q & (rd_q != 0) & (state == RUN).
//  WEN = live. Stall does not gate WEN; repeated identical write is idempotent.
//  fwd_valid = live; fwd_rd = rd_q; fwd_data = wdat.
//  Retire event: valid_q & en & (state == RUN). Flush does not cancel the WB-resident instr.
//  retire_cnt += 1 per retire event; saturates at 2**CNT_W-1, no wrap.
//  FSM, 2 states:
//   RUN    -> HALTED on a retire event with halt_q=1 (HALT itself is counted)
//   HALTED -> terminal until nRST; halt=1 registered, so asserted the cycle after HALT retires.
//  HALT latched but stalled (en=0): stays in RUN, halt=0 until en=1.
//  In HALTED: WEN=0, fwd_valid=0, retire_cnt frozen; wdat/wsel keep the last latched values.
//  Reset mid-operation: async clear to reset values, including from HALTED.
//  en and flush in the same cycle: the flush behaviour applies (bubble enters).
//   A retire event still occurs if valid_q=1.
//  Latency: 1 cycle from MEM inputs to WB outputs when en=1.
// TESTING
//  1 Reset: nRST=0 mid-stream -> all outputs 0 within same cycle; halt=0, retire_cnt=0.
//  2 Select sweep: src k = 32'hA000_000k, sel 0..4, regwen=1, rd=7, en=1
//    -> next cycle wdat=A000_000k, WEN=1; sel=5..7 -> wdat=0.
//  3 Stall/flush: latch rd=3, then en=0 for 3 cycles -> outputs held, retire_cnt +0;
//    flush=1 -> next cycle WEN=0, fwd_valid=0.
//  4 rd=0, regwen=1 -> WEN=0, fwd_valid=0, retire_cnt still +1.
//  5 HALT: temp_halt=1 with en=1 -> halt=1 one cycle after retire, retire_cnt +1;
//    later inputs ignored, WEN=0 for 20 cycles; nRST pulse -> halt=0.
//  6 Saturation: CNT_W=3, retire 10 instructions back-to-back -> retire_cnt=7 and held.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM/WB register, N-way writeback select, regfile write, WB->EX forward tap, sticky halt, retire counter.
// Latency: 1 cycle from MEM-stage inputs to WB outputs when en=1.
// Backpressure: en=0 holds the stage (no retire); flush inserts a bubble; HALTED freezes everything until nRST.
module wb_stage_pipe #(
  parameter int WORD_W  = 32,
  parameter int NSRC    = 5,
  parameter int SEL_W   = 3,   // 2**SEL_W must be >= NSRC
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   mem_valid,
  input  logic [SEL_W-1:0]       final_mux,
  input  logic [NSRC*WORD_W-1:0] src_data,
  input  logic [RADDR_W-1:0]     mem_rd,
  input  logic                   mem_regwen,
  input  logic                   temp_halt,
  output logic [WORD_W-1:0]      wdat,
  output logic [RADDR_W-1:0]     wsel,
  output logic                   WEN,
  output logic                   fwd_valid,
  output logic [RADDR_W-1:0]     fwd_rd,
  output logic [WORD_W-1:0]      fwd_data,
  output logic                   halt,
  output logic [CNT_W-1:0]       retire_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [NSRC*WORD_W-1:0]   src_q, src_d;
  logic [RADDR_W-1:0]       rd_q, rd_d;
  logic                     regwen_q, regwen_d;
  logic                     halt_q, halt_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     run;
  logic                     retire;
  logic                     live;
  logic [WORD_W-1:0]        wdat_sel;

  assign run    = (state_q == RUN);
  // The instruction sitting in WB retires whenever the stage advances, even if
  // the slot behind it is being flushed.
  assign retire = valid_q & en & run;
  assign live   = valid_q & regwen_q & (rd_q != '0) & run;

  // Pipeline register next-state: flush beats en, HALTED freezes all fields.
  always_comb begin
    valid_d  = valid_q;
    sel_d    = sel_q;
    src_d    = src_q;
    rd_d     = rd_q;
    regwen_d = regwen_q;
    halt_d   = halt_q;
    if (run) begin
      if (flush) begin
        valid_d = 1'b0;
      end else if (en) begin
        valid_d  = mem_valid;
        sel_d    = final_mux;
        src_d    = src_data;
        rd_d     = mem_rd;
        regwen_d = mem_regwen;
        halt_d   = temp_halt;
      end
    end
  end

  // Pipeline register state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= 1'b0;
      sel_q    <= '0;
      src_q    <= '0;
      rd_q     <= '0;
      regwen_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      src_q    <= src_d;
      rd_q     <= rd_d;
      regwen_q <= regwen_d;
      halt_q   <= halt_d;
    end
  end

  // Run/halt FSM next state: HALT is counted on the same retire that stops the core.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (retire && halt_q) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Run/halt FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Retire counter next value: saturating increment, never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Retire counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Writeback source select; selects beyond the last source read as zero.
  always_comb begin
    wdat_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_q == SEL_W'(k)) wdat_sel = src_q[k*WORD_W +: WORD_W];
    end
  end

  assign wdat       = wdat_sel;
  assign wsel       = rd_q;
  assign WEN        = live;
  assign fwd_valid  = live;
  assign fwd_rd     = rd_q;
  assign fwd_data   = wdat_sel;
  assign halt       = ~run;
  assign retire_cnt = cnt_q;

endmodule
